// File: rtl/fft_consts_pkg.sv
// Shared FFT constants, sample type and controller state encoding.
package fft_consts;

  localparam int unsigned N         = 16;
  localparam int unsigned LOG2N     = $clog2(N);
  localparam int unsigned MEM_LAT   = 1;
  localparam int unsigned BFU_LAT   = 3;
  localparam int unsigned DW        = 16;
  localparam int unsigned FRAC_BITS = 15;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT butterfly operand and twiddle address generator.
module fft_addr_gen #(
  parameter int unsigned LOG2N = 4,
  parameter int unsigned SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx
);

  logic [LOG2N-1:0] kk, half, j, g;
  logic [SW:0]      sh_grp, sh_tw;

  always_comb begin
    kk     = {1'b0, k};
    half   = LOG2N'(1) << stage;
    j      = kk & (half - LOG2N'(1));
    g      = kk >> stage;
    // One extra bit so stage+1 cannot wrap on the last stage.
    sh_grp = {1'b0, stage} + (SW + 1)'(1);
    sh_tw  = (SW + 1)'(LOG2N - 1) - {1'b0, stage};
    rd_addr_a = (g << sh_grp) | j;
    rd_addr_b = rd_addr_a + half;
    tw_idx    = (LOG2N - 1)'(j) << sh_tw;
  end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT scheduler: one butterfly per cycle, write-back
// addresses delayed to line up with the memory + bfu pipeline.
module fft_ctrl #(
  parameter int unsigned N       = fft_consts::N,
  parameter int unsigned LOG2N   = $clog2(N),
  parameter int unsigned MEM_LAT = fft_consts::MEM_LAT,
  parameter int unsigned BFU_LAT = fft_consts::BFU_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_idx,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b,
  output logic [$clog2(LOG2N)-1:0] stage
);

  import fft_consts::*;

  localparam int unsigned SW  = $clog2(LOG2N);
  localparam int unsigned KW  = LOG2N - 1;
  localparam int unsigned DLY = MEM_LAT + BFU_LAT;
  localparam int unsigned CW  = $clog2(DLY + 1);

  typedef struct packed {
    logic             valid;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wb_t;

  fft_ctrl_state_t  state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             issue_d;
  logic [LOG2N-1:0] gen_a, gen_b;
  logic [KW-1:0]    gen_tw;

  logic             busy_q, done_q, rd_en_q;
  logic [LOG2N-1:0] rd_a_q, rd_b_q;
  logic [KW-1:0]    tw_q;
  wb_t              pipe_q [DLY];

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          stage_d = '0;
          k_d     = '0;
        end
      end
      StRun: begin
        if (k_q == KW'(N / 2 - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDrain: begin
        // Hold off the next stage until its last write has landed.
        if (cnt_q == CW'(DLY - 1)) begin
          if (stage_q == SW'(LOG2N - 1)) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            stage_d = stage_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        stage_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign issue_d = (state_d == StRun);

  // Addresses come from the next-state counters so they register alongside rd_en.
  fft_addr_gen #(
    .LOG2N(LOG2N),
    .SW   (SW)
  ) u_addr_gen (
    .stage    (stage_d),
    .k        (k_d),
    .rd_addr_a(gen_a),
    .rd_addr_b(gen_b),
    .tw_idx   (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      for (int i = 0; i < int'(DLY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      rd_en_q <= issue_d;
      rd_a_q  <= issue_d ? gen_a : '0;
      rd_b_q  <= issue_d ? gen_b : '0;
      tw_q    <= issue_d ? gen_tw : '0;
      pipe_q[0] <= '{valid: rd_en_q, a: rd_a_q, b: rd_b_q};
      for (int i = 1; i < int'(DLY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_idx    = tw_q;
  assign stage     = stage_q;
  assign wr_en     = pipe_q[DLY-1].valid;
  assign wr_addr_a = pipe_q[DLY-1].a;
  assign wr_addr_b = pipe_q[DLY-1].b;

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl at N=16: address order, pipeline alignment,
// completion timing, ignored start and mid-run reset.
module tb_fft_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, rd_en, wr_en;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [2:0] tw_idx;
  logic [1:0] stage;

  int n_cmp = 0;
  int n_err = 0;

  // Hand-derived operand A addresses and twiddle indices per stage/butterfly.
  int exp_a [4][8] = '{'{0, 2, 4, 6, 8, 10, 12, 14},
                       '{0, 1, 4, 5, 8, 9, 12, 13},
                       '{0, 1, 2, 3, 8, 9, 10, 11},
                       '{0, 1, 2, 3, 4, 5, 6, 7}};
  int exp_t [4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                       '{0, 4, 0, 4, 0, 4, 0, 4},
                       '{0, 2, 4, 6, 0, 2, 4, 6},
                       '{0, 1, 2, 3, 4, 5, 6, 7}};
  int half_t [4] = '{1, 2, 4, 8};

  fft_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_idx   (tw_idx),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b),
    .stage    (stage)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle c (relative to the start-sampling cycle 0) issues a butterfly?
  function automatic bit issue_at(input int c, output int s, output int k);
    s = 0;
    k = 0;
    if (c < 1) return 1'b0;
    s = (c - 1) / 12;
    k = (c - 1) % 12;
    return (s < 4) && (k < 8);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".rd_en"}, 32'(rd_en), 0);
    chk({tag, ".wr_en"}, 32'(wr_en), 0);
    chk({tag, ".rd_a"}, 32'(rd_addr_a), 0);
    chk({tag, ".rd_b"}, 32'(rd_addr_b), 0);
    chk({tag, ".tw"}, 32'(tw_idx), 0);
    chk({tag, ".wr_a"}, 32'(wr_addr_a), 0);
    chk({tag, ".wr_b"}, 32'(wr_addr_b), 0);
    chk({tag, ".stage"}, 32'(stage), 0);
  endtask

  task automatic check_cycle(input string run, input int c);
    int    s, k, ws, wk;
    bit    rd, wr;
    string t;
    t  = $sformatf("%s@%0d", run, c);
    rd = issue_at(c, s, k);
    wr = issue_at(c - 4, ws, wk);
    chk({t, ".rd_en"}, 32'(rd_en), 32'(rd));
    if (rd) begin
      chk({t, ".rd_a"}, 32'(rd_addr_a), exp_a[s][k]);
      chk({t, ".rd_b"}, 32'(rd_addr_b), exp_a[s][k] + half_t[s]);
      chk({t, ".tw"}, 32'(tw_idx), exp_t[s][k]);
    end
    chk({t, ".wr_en"}, 32'(wr_en), 32'(wr));
    if (wr) begin
      chk({t, ".wr_a"}, 32'(wr_addr_a), exp_a[ws][wk]);
      chk({t, ".wr_b"}, 32'(wr_addr_b), exp_a[ws][wk] + half_t[ws]);
    end
    chk({t, ".busy"}, 32'(busy), 32'(c >= 1 && c <= 49));
    chk({t, ".done"}, 32'(done), 32'(c == 49));
    if (c >= 1 && c <= 48) chk({t, ".stage"}, 32'(stage), (c - 1) / 12);
  endtask

  initial begin
    // Reset held with start asserted: nothing moves.
    rst   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero($sformatf("rst%0d", i));
    end
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_zero($sformatf("idle%0d", i));
    end

    // Run 1, then re-start in its cycle 50.
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      start = 1'b0;
      check_cycle("r1", c);
    end
    start = 1'b1;

    // Run 2 with stray start pulses in cycles 10 and 49.
    for (int c = 1; c <= 50; c++) begin
      tick();
      start = (c == 10 || c == 49);
      check_cycle("r2", c);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post%0d.busy", i), 32'(busy), 0);
      chk($sformatf("post%0d.rd_en", i), 32'(rd_en), 0);
    end

    // Run 3 reset in cycle 20.
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      check_cycle("r3", c);
    end
    rst = 1'b0;
    tick();
    check_zero("mrst21");
    rst = 1'b1;
    for (int c = 22; c <= 25; c++) begin
      tick();
      chk($sformatf("mrst%0d.wr_en", c), 32'(wr_en), 0);
      chk($sformatf("mrst%0d.rd_en", c), 32'(rd_en), 0);
      chk($sformatf("mrst%0d.busy", c), 32'(busy), 0);
    end

    // Run 4 after the mid-run reset.
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      start = 1'b0;
      check_cycle("r4", c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

In-place radix-2 DIT FFT scheduler that sequences the shared `bfu` across all log2(N) stages. It issues one butterfly per cycle by driving:
- the read ports of a dual-port sample memory,
- the index of a twiddle ROM,
- the write-back addresses, delayed to match the memory + `bfu` pipeline.

It sits between the top-level FFT wrapper (start/done) and the memory/ROM/`bfu` datapath. Input samples are already in the memory in bit-reversed order before `start`.

## Interface
- `N`, 16: FFT size, power of two, ≥4.
- `LOG2N`, $clog2(N): stage count and address width.
- `MEM_LAT`, 1: sample-memory and twiddle-ROM read latency, in cycles.
- `BFU_LAT`, 3: `bfu` input-to-output latency, in cycles.

Ports (clock and reset first):
- `clk`  in  1  system clock; everything is synchronous to its rising edge.
- `rst`  in  1  synchronous active-low reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `busy`  out  1  transform in progress.
- `done`  out  1  one-cycle pulse when the transform is complete.
- `rd_en`  out  1  memory read strobe (one butterfly issued).
- `rd_addr_a`, `rd_addr_b`  out  LOG2N each  butterfly operand addresses.
- `tw_idx`  out  LOG2N-1  twiddle ROM index; issued in the same cycle as `rd_en`.
- `wr_en`  out  1  write-back strobe.
- `wr_addr_a`, `wr_addr_b`  out  LOG2N each  write-back addresses for `A_out` and `B_out`.
- `stage`  out  $clog2(LOG2N)  current stage number, for debug.

## Operation
- FSM states and transitions:
  - IDLE: goes to RUN when `start`=1.
  - RUN: issues N/2 butterflies, one per cycle; after issue k=N/2-1 it goes to DRAIN.
  - DRAIN: waits MEM_LAT+BFU_LAT cycles; then goes to RUN with `stage`+1, or to DONE if `stage`=LOG2N-1.
  - DONE: lasts one cycle, then returns to IDLE.
- Address generation for stage s and butterfly k:
  - half = 1<<s, j = k & (half-1), g = k >> s.
  - `rd_addr_a` = (g<<(s+1)) | j; `rd_addr_b` = `rd_addr_a` + half.
  - `tw_idx` = j << (LOG2N-1-s).
  - All arithmetic is unsigned and LOG2N bits wide; no overflow is possible.
- Write-back delay line:
  - Depth MEM_LAT+BFU_LAT, carrying {valid, addr_a, addr_b}.
  - `wr_en`/`wr_addr_*` equal the `rd_en`/`rd_addr_*` of exactly MEM_LAT+BFU_LAT cycles earlier.
- Stage hazard: the first read of stage s+1 occurs strictly after the last write of stage s. The memory gives no read-during-write bypass.
- `start` is ignored in RUN, DRAIN and DONE.
- Reset mid-operation (`rst`=0 in any state):
  - The next state is IDLE.
  - The delay line is cleared, so no `wr_en` is emitted for butterflies issued before reset.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en` are 0; all addresses, `tw_idx` and `stage` are 0.
- With `start` sampled high at cycle 0:
  - The first `rd_en` is at cycle 1.
  - Stage s issues on cycles 1+s·(N/2+4) through s·(N/2+4)+N/2.
- DRAIN lasts 4 cycles (MEM_LAT+BFU_LAT). The last `wr_en` of a stage coincides with the final DRAIN cycle.
- The next stage's first issue follows one cycle later: a 5-cycle gap between issues.
- `done` pulses at cycle LOG2N·(N/2+4)+1 (49 for N=16).
- `busy` is 1 from cycle 1 through the `done` cycle inclusive.
- `rd_en` is 1 continuously for all N/2 cycles of RUN; there are no bubbles.

## Structure
- Add to `fft_consts`: `N`, `LOG2N`, `MEM_LAT`, `BFU_LAT`, and the FSM state enum `fft_ctrl_state_t`. `complex_t`, `DW` and `FRAC_BITS` stay there unchanged.
- Sub-module `fft_addr_gen`:
  - Inputs: stage, k.
  - Outputs: `rd_addr_a`, `rd_addr_b`, `tw_idx`.
  - Combinational; registered in `fft_ctrl`.
- The delay line is inline in `fft_ctrl`.

## Test plan
- Reset: hold `rst`=0 with `start`=1 for 3 cycles -> all outputs 0 and no state change. Release `rst` -> outputs remain 0 until `start`.
- Address sequence, N=16, one `start` pulse:
  - Stage 0 pairs (0,1),(2,3)…(14,15), `tw_idx` all 0.
  - Stage 1 pairs (0,2),(1,3),(4,6)…, `tw_idx` 0,4,0,4….
  - Stage 3 pairs (0,8)…(7,15), `tw_idx` 0..7.
- Pipeline alignment: every `wr_en` is exactly 4 cycles after its `rd_en`, with identical addresses. The last write of stage s precedes the first read of stage s+1 by 1 cycle.
- Completion timing: `start` at cycle 0 -> `done` at cycle 49 only; `busy` spans cycles 1–49. Re-`start` at cycle 50 repeats the identical sequence.
- Ignored start: pulse `start` at cycles 10 and 49 -> no disturbance to the sequence and no second run.
- Mid-run reset: `rst`=0 at cycle 20 -> outputs are 0 from cycle 21 and no `wr_en` appears in cycles 21–25. A new `start` runs cleanly.
